ram: RTL and testbench
======================

RAM -- requirements
Module: ram

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, gives clock cycles per UART bit (50 MHz / 115200 baud).
REQ-002 Parameter ADDR_W, default 4, gives the memory address width; depth is 2^ADDR_W bytes.
REQ-003 The port list SHALL be as follows, clock and reset first:
- clk  in  1  single system clock; all state on rising edge.
- nRst  in  1  asynchronous, active-low reset.
- rx  in  1  UART receive line, asynchronous to clk.
- sw2, sw1, sw0  in  1 each  display address select, asynchronous.
- tx  out  1  UART transmit line.
- led4  out  1  activity indicator.
- led3, led2, led1, led0  out  1 each  display data nibble.
REQ-004 There SHALL be one clock; reset is asynchronous and active-low.

Function
REQ-005 rx and sw2..sw0 SHALL each pass through a 2-flop synchronizer before use.
REQ-006 UART framing SHALL be 8N1, LSB first, idle high, at CLKS_PER_BIT cycles per bit.
REQ-007 The receiver SHALL arm only after the synchronized rx has been high for CLKS_PER_BIT consecutive cycles; a low line at or after reset is not a start bit.
REQ-008 The receiver SHALL detect a start edge, re-check rx low at mid-bit (glitch, then return to idle), and sample data and stop bits at mid-bit.
REQ-009 A stop bit sampled 0 SHALL discard the byte, leave the parser state unchanged, and re-arm per REQ-007.
REQ-010 Memory SHALL be 2^ADDR_W x 8-bit registers.
REQ-011 The parser SHALL have two states, CMD and DATA.
REQ-012 In CMD, a received byte C with C[7]=1 SHALL latch address C[ADDR_W-1:0] and move to DATA.
REQ-013 In CMD, a byte with C[7]=0 SHALL queue a read response of mem[C[ADDR_W-1:0]]; C[6:ADDR_W] are ignored.
REQ-014 In DATA, the next valid byte D SHALL be written to the latched address one cycle after its stop-bit sample, and the parser SHALL return to CMD; there is no timeout.
REQ-015 A read of an address in the same cycle it is written SHALL return the new data.
REQ-016 The transmitter SHALL start the start bit within 2 cycles of a queued response when idle.
REQ-017 The transmitter SHALL drive 10 bits of CLKS_PER_BIT cycles each, then return to idle high.
REQ-018 A one-entry pending register SHALL hold a response queued while tx is busy; a response arriving while pending is full SHALL be dropped.
REQ-019 led3..led0 SHALL be registered and equal mem[{0, sw2, sw1, sw0}][3:0], updating 1 cycle after a memory or synchronized-switch change.
REQ-020 led4 SHALL be registered and high while the receiver is mid-frame or the transmitter or pending register is busy.

Reset
REQ-021 While nRst=0: tx=1, led4..led0=0, all memory bytes 0, parser in CMD, receiver disarmed, transmitter idle, pending empty, synchronizers 0.
REQ-022 Reset asserted mid-frame SHALL abort the receive or transmit immediately; tx goes high asynchronously.

Verification (CLKS_PER_BIT=4)
REQ-023 Reset pulse with rx=0, switches toggled, then rx=1 -> tx stays 1, led4 stays 0, led3..0=0, no byte accepted.
REQ-024 After 4+ idle-high bits, send 0x83 then 0xA5, set sw=011 -> led3..0=0101 and mem[3]=0xA5.
REQ-025 Send read command 0x03 -> tx emits frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1), led4 high during the frame.
REQ-026 Send 0x85 with stop bit 0 -> byte discarded; then 0x05 -> tx returns 0x00 (no write occurred).
REQ-027 Send two read commands back-to-back, 0x03 then 0x00 -> two frames 0xA5 then 0x00, none dropped.
REQ-028 Assert nRst during a tx frame -> tx=1 immediately, memory cleared, led3..0=0.

Source files
------------

// File: rtl/ram.sv
// ---------------------------------------------------------------------------
// ram -- UART-controlled 2^ADDR_W x 8 register memory.
//
// A byte arriving on rx is interpreted by a two-state parser:
//   CMD : C[7]=1 latches address C[ADDR_W-1:0] and waits for a data byte;
//         C[7]=0 returns mem[C[ADDR_W-1:0]] on tx as one 8N1 frame.
//   DATA: the next good byte is written to the latched address.
// A one-entry pending register absorbs a read that arrives while tx is busy.
//
// Ports
//   clk             system clock, all state on the rising edge
//   nRst            asynchronous active-low reset
//   rx              UART receive line (asynchronous, 8N1, LSB first)
//   sw2, sw1, sw0   address select for the LED display (asynchronous)
//   tx              UART transmit line, idle high
//   led4            activity: receive in progress, transmit or pending busy
//   led3..led0      low nibble of mem[{0, sw2, sw1, sw0}]
// ---------------------------------------------------------------------------
module ram #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 4
) (
  input  logic clk,
  input  logic nRst,
  input  logic rx,
  input  logic sw2,
  input  logic sw1,
  input  logic sw0,
  output logic tx,
  output logic led4,
  output logic led3,
  output logic led2,
  output logic led1,
  output logic led0
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam int MID   = (CLKS_PER_BIT - 1) / 2;
  localparam int LAST  = CLKS_PER_BIT - 1;

  typedef enum logic [2:0] {
    RX_DISARM, RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  typedef enum logic {P_CMD, P_DATA} parse_state_t;

  // ---------------- input synchronizers ----------------
  logic [1:0] r_rx_sync;
  logic [2:0] r_sw_meta, r_sw_sync;
  logic       w_rx;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_rx_sync <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_rx_sync <= {r_rx_sync[0], rx};
      r_sw_meta <= {sw2, sw1, sw0};
      r_sw_sync <= r_sw_meta;
    end
  end

  assign w_rx = r_rx_sync[1];

  // ---------------- receiver ----------------
  rx_state_t        r_rx_state;
  logic [CNT_W-1:0] r_rx_cnt;
  logic [2:0]       r_rx_bit;
  logic [7:0]       r_rx_shift;
  logic             r_rx_valid;

  // RX_DISARM counts consecutive high cycles; a line that is low at or
  // after reset (or after a framing error) must idle a full bit first.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_rx_state <= RX_DISARM;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      unique case (r_rx_state)
        RX_DISARM: begin
          if (!w_rx) begin
            r_rx_cnt <= '0;
          end else if (r_rx_cnt == CNT_W'(LAST)) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        RX_IDLE: begin
          if (!w_rx) begin
            r_rx_cnt   <= '0;
            r_rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (r_rx_cnt == CNT_W'(MID)) begin
            // Still low at mid-bit: real start bit. Otherwise a glitch.
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_state <= w_rx ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == CNT_W'(LAST)) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {w_rx, r_rx_shift[7:1]};
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
            else                  r_rx_bit   <= r_rx_bit + 3'd1;
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == CNT_W'(LAST)) begin
            r_rx_cnt <= '0;
            if (w_rx) begin
              r_rx_valid <= 1'b1;
              r_rx_state <= RX_IDLE;
            end else begin
              r_rx_state <= RX_DISARM;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
          end
        end
        default: r_rx_state <= RX_DISARM;
      endcase
    end
  end

  // ---------------- parser and memory ----------------
  parse_state_t      r_pstate;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_mem [DEPTH];
  logic              w_wr_en, w_cmd_rd;
  logic [ADDR_W-1:0] w_rd_addr, w_sw_addr;
  logic [7:0]        w_rd_data;

  assign w_wr_en   = r_rx_valid && (r_pstate == P_DATA);
  assign w_cmd_rd  = r_rx_valid && (r_pstate == P_CMD) && !r_rx_shift[7];
  assign w_rd_addr = r_rx_shift[ADDR_W-1:0];
  assign w_sw_addr = ADDR_W'(r_sw_sync);
  // Write-through so a same-cycle write is visible to the read response.
  assign w_rd_data = (w_wr_en && (r_addr == w_rd_addr)) ? r_rx_shift
                                                        : r_mem[w_rd_addr];

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_pstate <= P_CMD;
      r_addr   <= '0;
    end else if (r_rx_valid) begin
      if (r_pstate == P_DATA) begin
        r_pstate <= P_CMD;
      end else if (r_rx_shift[7]) begin
        r_addr   <= r_rx_shift[ADDR_W-1:0];
        r_pstate <= P_DATA;
      end
    end
  end

  // NOTE: the memory is small and must read back as zero after reset, so it
  // is built from resettable flops rather than an inferred RAM macro.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[r_addr] <= r_rx_shift;
    end
  end

  // ---------------- transmitter with one-entry pending ----------------
  logic             r_tx, r_tx_busy, r_pend_valid;
  logic [8:0]       r_tx_shift;
  logic [7:0]       r_pend_data;
  logic [CNT_W-1:0] r_tx_cnt;
  logic [3:0]       r_tx_nbit;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_tx         <= 1'b1;
      r_tx_busy    <= 1'b0;
      r_tx_shift   <= '1;
      r_tx_cnt     <= '0;
      r_tx_nbit    <= '0;
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
    end else if (!r_tx_busy) begin
      if (r_pend_valid || w_cmd_rd) begin
        // Older pending response goes first; a new one takes its slot.
        r_tx         <= 1'b0;
        r_tx_busy    <= 1'b1;
        r_tx_cnt     <= '0;
        r_tx_nbit    <= '0;
        r_tx_shift   <= {1'b1, r_pend_valid ? r_pend_data : w_rd_data};
        r_pend_valid <= r_pend_valid && w_cmd_rd;
        r_pend_data  <= w_rd_data;
      end
    end else begin
      if (r_tx_cnt == CNT_W'(LAST)) begin
        r_tx_cnt <= '0;
        if (r_tx_nbit == 4'd9) begin
          r_tx      <= 1'b1;
          r_tx_busy <= 1'b0;
        end else begin
          r_tx       <= r_tx_shift[0];
          r_tx_shift <= {1'b1, r_tx_shift[8:1]};
          r_tx_nbit  <= r_tx_nbit + 4'd1;
        end
      end else begin
        r_tx_cnt <= r_tx_cnt + CNT_W'(1);
      end
      // Response during a frame: park it, or drop it if the slot is full.
      if (w_cmd_rd && !r_pend_valid) begin
        r_pend_valid <= 1'b1;
        r_pend_data  <= w_rd_data;
      end
    end
  end

  // ---------------- status LEDs ----------------
  logic [3:0] r_led;
  logic       r_led4;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_led  <= '0;
      r_led4 <= 1'b0;
    end else begin
      r_led  <= r_mem[w_sw_addr][3:0];
      r_led4 <= (r_rx_state == RX_START) || (r_rx_state == RX_DATA) ||
                (r_rx_state == RX_STOP)  || r_tx_busy || r_pend_valid;
    end
  end

  assign tx   = r_tx;
  assign led4 = r_led4;
  assign {led3, led2, led1, led0} = r_led;

endmodule

// File: tb/tb_ram.sv
// ---------------------------------------------------------------------------
// tb_ram -- self-checking bench for ram with CLKS_PER_BIT=4, ADDR_W=4.
// A monitor decodes every tx frame and compares it with the next entry of
// a queue of expected responses; a table of command bytes exercises the
// parser and LED display, followed by hand-written multi-cycle sequences.
// ---------------------------------------------------------------------------
module tb_ram;

  localparam int CPB    = 4;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic nRst, rx, sw2, sw1, sw0;
  logic tx, led4, led3, led2, led1, led0;

  always #5 clk = ~clk;

  ram #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .nRst(nRst), .rx(rx),
    .sw2(sw2), .sw1(sw1), .sw0(sw0),
    .tx(tx), .led4(led4),
    .led3(led3), .led2(led2), .led1(led1), .led0(led0)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  bit         mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] leds();
    return {led3, led2, led1, led0};
  endfunction

  task automatic set_sw(input logic [2:0] s);
    {sw2, sw1, sw0} = s;
  endtask

  // Drive one 8N1 frame on rx, then gap_bits idle-high bit times.
  task automatic send_byte(input logic [7:0] d, input logic stop,
                           input int gap_bits);
    @(negedge clk) rx = 1'b0;
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) rx = d[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk) rx = stop;
    repeat (CPB - 1) @(negedge clk);
    @(negedge clk) rx = 1'b1;
    repeat (CPB * gap_bits) @(negedge clk);
  endtask

  task automatic wait_q_empty(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_resp_pending"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (6) @(negedge clk);
  endtask

  // Frame monitor: samples tx on the falling edge, mid-bit.
  initial begin
    forever begin
      @(negedge clk);
      if (nRst && mon_en && tx == 1'b0) begin : frame
        logic [7:0] got;
        got = '0;
        repeat (CPB / 2) @(negedge clk);
        check("tx_start_bit", 32'(tx), 32'd0);
        check("led4_during_tx", 32'(led4), 32'd1);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          got[i] = tx;
        end
        repeat (CPB) @(negedge clk);
        check("tx_stop_bit", 32'(tx), 32'd1);
        if (exp_q.size() == 0) begin
          check("tx_unexpected_frame", 32'(got), 32'hFFFF_FFFF);
        end else begin
          check("tx_frame_data", 32'(got), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic [2:0] sw;
    logic       has_resp;
    logic [7:0] resp;
    logic [3:0] led;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int bad;

    // {byte, stop bit, switches, response expected, response, LEDs}
    vecs[0]  = '{8'h83, 1'b1, 3'b000, 1'b0, 8'h00, 4'h0}; // address 3
    vecs[1]  = '{8'hA5, 1'b1, 3'b011, 1'b0, 8'h00, 4'h5}; // mem[3]=A5
    vecs[2]  = '{8'h03, 1'b1, 3'b011, 1'b1, 8'hA5, 4'h5}; // read 3
    vecs[3]  = '{8'h85, 1'b0, 3'b011, 1'b0, 8'h00, 4'h5}; // framing error
    vecs[4]  = '{8'h05, 1'b1, 3'b101, 1'b1, 8'h00, 4'h0}; // read 5: no write
    vecs[5]  = '{8'h81, 1'b1, 3'b001, 1'b0, 8'h00, 4'h0}; // address 1
    vecs[6]  = '{8'h3C, 1'b1, 3'b001, 1'b0, 8'h00, 4'hC}; // mem[1]=3C
    vecs[7]  = '{8'h71, 1'b1, 3'b001, 1'b1, 8'h3C, 4'hC}; // C[6:4] ignored
    vecs[8]  = '{8'h8F, 1'b1, 3'b111, 1'b0, 8'h00, 4'h0}; // address 15
    vecs[9]  = '{8'hF7, 1'b1, 3'b111, 1'b0, 8'h00, 4'h0}; // mem[15]=F7
    vecs[10] = '{8'h0F, 1'b1, 3'b111, 1'b1, 8'hF7, 4'h0}; // read 15
    vecs[11] = '{8'h87, 1'b1, 3'b111, 1'b0, 8'h00, 4'h0}; // address 7
    vecs[12] = '{8'h9E, 1'b1, 3'b111, 1'b0, 8'h00, 4'hE}; // bit7 data

    // ---- reset with rx low and switches moving ----
    nRst = 1'b0;
    rx   = 1'b0;
    set_sw(3'b000);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) set_sw(3'(i));
    end
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_led4", 32'(led4), 32'd0);
    check("rst_leds", 32'(leds()), 32'd0);
    @(negedge clk) nRst = 1'b1;
    mon_en = 1'b1;
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i % 3 == 0) set_sw(3'(i));
      if (tx !== 1'b1 || led4 !== 1'b0 || leds() !== 4'h0) bad++;
    end
    rx = 1'b1;
    for (int i = 0; i < 6 * CPB; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || led4 !== 1'b0 || leds() !== 4'h0) bad++;
    end
    check("post_rst_quiet_cycles_bad", 32'(bad), 32'd0);

    // ---- table-driven command vectors ----
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].has_resp) exp_q.push_back(vecs[i].resp);
      send_byte(vecs[i].data, vecs[i].stop, 2);
      wait_q_empty($sformatf("vec%0d", i), 200);
      set_sw(vecs[i].sw);
      repeat (6) @(negedge clk);
      check($sformatf("vec%0d_leds", i), 32'(leds()), 32'(vecs[i].led));
    end
    check("idle_led4", 32'(led4), 32'd0);

    // ---- one-cycle glitch on rx must not be taken as a start bit ----
    @(negedge clk) rx = 1'b0;
    @(negedge clk) rx = 1'b1;
    repeat (5 * CPB) @(negedge clk);
    check("glitch_led4", 32'(led4), 32'd0);
    exp_q.push_back(8'hA5);
    send_byte(8'h03, 1'b1, 2);
    wait_q_empty("glitch_then_read", 200);

    // ---- back-to-back reads: second one waits in the pending slot ----
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h00);
    send_byte(8'h03, 1'b1, 0);
    send_byte(8'h00, 1'b1, 2);
    wait_q_empty("back_to_back", 400);
    set_sw(3'b011);
    repeat (6) @(negedge clk);
    check("b2b_leds", 32'(leds()), 32'h5);

    // ---- reset in the middle of a tx frame ----
    mon_en = 1'b0;
    send_byte(8'h03, 1'b1, 0);
    bad = 1;
    for (int i = 0; i < 40 && bad != 0; i++) begin
      if (tx === 1'b0) bad = 0;
      else @(negedge clk);
    end
    check("midframe_tx_started", 32'(bad), 32'd0);
    repeat (2 * CPB + 1) @(negedge clk);
    check("midframe_led4_busy", 32'(led4), 32'd1);
    #2 nRst = 1'b0;
    #1;
    check("midframe_rst_tx", 32'(tx), 32'd1);
    check("midframe_rst_led4", 32'(led4), 32'd0);
    check("midframe_rst_leds", 32'(leds()), 32'd0);
    repeat (3) @(negedge clk);
    nRst = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    mon_en = 1'b1;
    exp_q.push_back(8'h00);
    send_byte(8'h03, 1'b1, 2);
    wait_q_empty("after_rst_read", 200);
    check("after_rst_leds", 32'(leds()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
